ps2_key_bridge: RTL and testbench

//  Downstream of the ps2 scancode receiver, upstream of the uart transmitter.

---
 rtl/ps2_key_pkg.sv | 34 +++
 rtl/ps2_scan_to_ascii.sv | 70 +++++++
 rtl/ps2_key_bridge.sv | 166 ++++++++++++++++
 tb/tb_ps2_key_bridge.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// Shared encodings for the PS/2 keyboard-to-UART bridge: FSM states,
// set-2 scancode constants and ASCII constants.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    P_IDLE,
    P_BRK,
    P_EXT,
    P_EXTBRK
  } parse_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_HOLD,
    T_WAIT
  } tx_state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 make-code to ASCII translation; letters honour
// shift XOR caps, digits honour shift only, control keys ignore both.
module ps2_scan_to_ascii
  import ps2_key_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       caps,
  output logic       valid,
  output logic [7:0] ascii
);

  logic       letter;
  logic [7:0] base;

  always_comb begin
    valid  = 1'b1;
    letter = 1'b0;
    base   = 8'h00;
    case (scancode)
      8'h1C: begin letter = 1'b1; base = 8'h61; end
      8'h32: begin letter = 1'b1; base = 8'h62; end
      8'h21: begin letter = 1'b1; base = 8'h63; end
      8'h23: begin letter = 1'b1; base = 8'h64; end
      8'h24: begin letter = 1'b1; base = 8'h65; end
      8'h2B: begin letter = 1'b1; base = 8'h66; end
      8'h34: begin letter = 1'b1; base = 8'h67; end
      8'h33: begin letter = 1'b1; base = 8'h68; end
      8'h43: begin letter = 1'b1; base = 8'h69; end
      8'h3B: begin letter = 1'b1; base = 8'h6A; end
      8'h42: begin letter = 1'b1; base = 8'h6B; end
      8'h4B: begin letter = 1'b1; base = 8'h6C; end
      8'h3A: begin letter = 1'b1; base = 8'h6D; end
      8'h31: begin letter = 1'b1; base = 8'h6E; end
      8'h44: begin letter = 1'b1; base = 8'h6F; end
      8'h4D: begin letter = 1'b1; base = 8'h70; end
      8'h15: begin letter = 1'b1; base = 8'h71; end
      8'h2D: begin letter = 1'b1; base = 8'h72; end
      8'h1B: begin letter = 1'b1; base = 8'h73; end
      8'h2C: begin letter = 1'b1; base = 8'h74; end
      8'h3C: begin letter = 1'b1; base = 8'h75; end
      8'h2A: begin letter = 1'b1; base = 8'h76; end
      8'h1D: begin letter = 1'b1; base = 8'h77; end
      8'h22: begin letter = 1'b1; base = 8'h78; end
      8'h35: begin letter = 1'b1; base = 8'h79; end
      8'h1A: begin letter = 1'b1; base = 8'h7A; end
      // Top-row digits; shifted symbols follow the US layout.
      8'h16: base = shift ? 8'h21 : 8'h31;
      8'h1E: base = shift ? 8'h40 : 8'h32;
      8'h26: base = shift ? 8'h23 : 8'h33;
      8'h25: base = shift ? 8'h24 : 8'h34;
      8'h2E: base = shift ? 8'h25 : 8'h35;
      8'h36: base = shift ? 8'h5E : 8'h36;
      8'h3D: base = shift ? 8'h26 : 8'h37;
      8'h3E: base = shift ? 8'h2A : 8'h38;
      8'h46: base = shift ? 8'h28 : 8'h39;
      8'h45: base = shift ? 8'h29 : 8'h30;
      8'h29:    base = ASCII_SPACE;
      SC_ENTER: base = ASCII_CR;
      8'h66:    base = 8'h08;
      8'h0D:    base = 8'h09;
      8'h76:    base = 8'h1B;
      // Caps lock never produces a character; the bridge owns its state.
      SC_CAPS:  valid = 1'b0;
      default:  valid = 1'b0;
    endcase
    ascii = (letter && (shift ^ caps)) ? (base - ASCII_CASE_DELTA) : base;
  end

endmodule

// File: rtl/ps2_key_bridge.sv
// PS/2 set-2 scancode parser, character FIFO and UART send handshake.
// Define KBD_CAPSLOCK_EN to enable caps-lock tracking; otherwise caps_on is 0.
module ps2_key_bridge
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    scancode,
  input  logic                          new_code,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_en,
  output logic [7:0]                    last_ascii,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          shift_on,
  output logic                          caps_on
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  parse_state_t pstate, pstate_next;
  tx_state_t    tstate, tstate_next;

  logic             tbl_valid;
  logic [7:0]       tbl_ascii;
  logic             push, pop, accept, full;
  logic [7:0]       push_char;
  logic             shift_set, shift_clr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  ps2_scan_to_ascii u_table (
    .scancode (scancode),
    .shift    (shift_on),
    .caps     (caps_on),
    .valid    (tbl_valid),
    .ascii    (tbl_ascii)
  );

  // Parser: one step per received byte.
  always_ff @(posedge clk) begin
    if (!rst_n) pstate <= P_IDLE;
    else        pstate <= pstate_next;
  end

  always_comb begin
    pstate_next = pstate;
    push        = 1'b0;
    push_char   = tbl_ascii;
    shift_set   = 1'b0;
    shift_clr   = 1'b0;
    if (new_code) begin
      case (pstate)
        P_IDLE: begin
          if (scancode == SC_BREAK)    pstate_next = P_BRK;
          else if (scancode == SC_EXT) pstate_next = P_EXT;
          else if (is_shift(scancode)) shift_set   = 1'b1;
          else                         push        = tbl_valid;
        end
        P_BRK: begin
          shift_clr   = is_shift(scancode);
          pstate_next = P_IDLE;
        end
        P_EXT: begin
          if (scancode == SC_BREAK) begin
            pstate_next = P_EXTBRK;
          end else begin
            pstate_next = P_IDLE;
            if (scancode == SC_ENTER) begin
              push      = 1'b1;
              push_char = ASCII_CR;
            end
          end
        end
        default: pstate_next = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         shift_on <= 1'b0;
    else if (shift_set) shift_on <= 1'b1;
    else if (shift_clr) shift_on <= 1'b0;
  end

`ifdef KBD_CAPSLOCK_EN
  // caps_held suppresses typematic repeats of 58 until its break arrives.
  logic caps_held;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      caps_on   <= 1'b0;
      caps_held <= 1'b0;
    end else if (new_code && (scancode == SC_CAPS)) begin
      if ((pstate == P_IDLE) && !caps_held) begin
        caps_on   <= !caps_on;
        caps_held <= 1'b1;
      end else if (pstate == P_BRK) begin
        caps_held <= 1'b0;
      end
    end
  end
`else
  assign caps_on = 1'b0;
`endif

  // FIFO: a full queue still accepts a push when the same cycle pops.
  assign full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop    = (tstate == T_SEND);
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      last_ascii <= 8'h00;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_ascii <= push_char;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!accept && pop) fifo_count <= fifo_count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // TX handshake: head is latched on entry to T_SEND so tx_data is valid
  // alongside tx_en, and a simultaneous push into the popped slot is safe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tstate  <= T_IDLE;
      tx_data <= 8'h00;
    end else begin
      tstate <= tstate_next;
      if ((tstate == T_IDLE) && (tstate_next == T_SEND)) tx_data <= mem[rd_ptr];
    end
  end

  always_comb begin
    tstate_next = tstate;
    tx_en       = 1'b0;
    case (tstate)
      T_IDLE: if ((fifo_count != '0) && !tx_busy) tstate_next = T_SEND;
      T_SEND: begin
        tx_en       = 1'b1;
        tstate_next = T_HOLD;
      end
      T_HOLD: tstate_next = T_WAIT;
      T_WAIT: if (!tx_busy) tstate_next = T_IDLE;
      default: tstate_next = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_key_bridge.sv
// Scoreboard bench for ps2_key_bridge: a keyboard-level reference model
// predicts characters, a monitor pops them as the DUT strobes tx_en.
`timescale 1ns/1ps
module tb_ps2_key_bridge;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] scancode;
  logic       new_code;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [7:0] last_ascii;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       shift_on;
  logic       caps_on;

  logic uart_busy = 1'b0;
  logic hold_busy = 1'b0;
  assign tx_busy = uart_busy | hold_busy;

  ps2_key_bridge #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scancode   (scancode),
    .new_code   (new_code),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .last_ascii (last_ascii),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .shift_on   (shift_on),
    .caps_on    (caps_on)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keyboard state plus the ordered list of expected chars.
  logic [7:0] t_lo [256];
  logic [7:0] t_up [256];
  bit         t_ok [256];
  bit         t_letter [256];
  logic [7:0] q [$];
  bit         m_brk, m_ext, m_shift, m_caps, m_caps_held, m_ovf;
  logic [7:0] m_last;
  int         m_room;

  function automatic void build_tables();
    logic [7:0] lc [26];
    logic [7:0] dc [10];
    logic [7:0] sc [5];
    logic [7:0] sv [5];
    string ds, ss;
    lc = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
           8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    dc = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
    sc = '{8'h29,8'h5A,8'h66,8'h0D,8'h76};
    sv = '{8'h20,8'h0D,8'h08,8'h09,8'h1B};
    ds = "1234567890";
    ss = "!@#$%^&*()";
    for (int i = 0; i < 256; i++) begin
      t_ok[i] = 0; t_letter[i] = 0; t_lo[i] = 8'h00; t_up[i] = 8'h00;
    end
    for (int i = 0; i < 26; i++) begin
      t_ok[lc[i]] = 1; t_letter[lc[i]] = 1;
      t_lo[lc[i]] = 8'h61 + 8'(i); t_up[lc[i]] = 8'h41 + 8'(i);
    end
    for (int i = 0; i < 10; i++) begin
      t_ok[dc[i]] = 1; t_lo[dc[i]] = ds[i]; t_up[dc[i]] = ss[i];
    end
    for (int i = 0; i < 5; i++) begin
      t_ok[sc[i]] = 1; t_lo[sc[i]] = sv[i]; t_up[sc[i]] = sv[i];
    end
  endfunction

  function automatic void model_reset();
    m_brk = 0; m_ext = 0; m_shift = 0; m_caps = 0; m_caps_held = 0;
    m_ovf = 0; m_last = 8'h00; m_room = -1;
    q.delete();
  endfunction

  // m_room < 0: queue cannot fill; otherwise it is the free space left
  // while the UART is held busy and nothing drains.
  function automatic void emit(input logic [7:0] c);
    if (m_room == 0) begin
      m_ovf = 1;
    end else begin
      q.push_back(c);
      m_last = c;
      if (m_room > 0) m_room--;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit upper;
    if (m_brk) begin
      if (!m_ext) begin
        if (b == 8'h12 || b == 8'h59) m_shift = 0;
        if (b == 8'h58) m_caps_held = 0;
      end
      m_brk = 0; m_ext = 0;
      return;
    end
    if (m_ext) begin
      if (b == 8'hF0) begin m_brk = 1; return; end
      if (b == 8'h5A) emit(8'h0D);
      m_ext = 0;
      return;
    end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'h12 || b == 8'h59) begin m_shift = 1; return; end
`ifdef KBD_CAPSLOCK_EN
    if (b == 8'h58) begin
      if (!m_caps_held) begin m_caps = !m_caps; m_caps_held = 1; end
      return;
    end
`endif
    if (!t_ok[b]) return;
    upper = t_letter[b] ? (m_shift ^ m_caps) : m_shift;
    emit(upper ? t_up[b] : t_lo[b]);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #2;
    scancode = b; new_code = 1'b1;
    model_byte(b);
    @(posedge clk); #2;
    new_code = 1'b0;
    @(negedge clk);
    check("shift_on", shift_on, m_shift);
    check("caps_on", caps_on, m_caps);
    check("last_ascii", last_ascii, m_last);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic wait_drain();
    int streak;
    streak = 0;
    for (int i = 0; i < 4000 && streak < 4; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !tx_busy && !tx_en) streak++;
      else streak = 0;
    end
    check("drain_done", 32'(streak >= 4), 1);
    check("fifo_empty", fifo_count, 0);
  endtask

  // UART stand-in: busy rises the cycle after tx_en and lasts a random time.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_en) begin
        @(posedge clk); #2;
        uart_busy = 1'b1;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #2;
        uart_busy = 1'b0;
      end
    end
  end

  // Monitor: every tx_en consumes the oldest expected character.
  bit prev_en = 0;
  bit prev_busy = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_en) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_unexpected: tx_data=%0h sent with nothing expected at %0t", tx_data, $time);
        end else begin
          check("tx_data", tx_data, q.pop_front());
        end
        check("tx_en_gap", prev_en, 0);
        check("tx_en_after_busy", prev_busy, 0);
      end
      prev_en   = tx_en;
      prev_busy = tx_busy;
    end
  end

  initial begin
    bit seen;
    int r;
    logic [7:0] pool [16];
    pool = '{8'h1C,8'h32,8'h1A,8'h15,8'h4D,8'h16,8'h1E,8'h45,8'h36,8'h29,8'h5A,8'h66,8'h0D,8'h76,8'h2B,8'h35};
    build_tables();
    model_reset();
    rst_n = 1'b0; new_code = 1'b0; scancode = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_last_ascii", last_ascii, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_shift", shift_on, 0);
    check("rst_caps", caps_on, 0);

    // Single make/break.
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    wait_drain();

    // Shift held around one letter, then a digit unshifted.
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1E);
    wait_drain();

    // Extended keys: only keypad Enter produces a character.
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0);
    send_byte(8'h75); send_byte(8'hE0); send_byte(8'h5A);
    wait_drain();

`ifdef KBD_CAPSLOCK_EN
    send_byte(8'h58); send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    check("caps_set", caps_on, 1);
    send_byte(8'h1C);
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    check("caps_clear", caps_on, 0);
    wait_drain();
`endif

    // Full FIFO, then a push landing in the same cycle as the pop.
    @(posedge clk); #2 hold_busy = 1'b1;
    m_room = DEPTH;
    for (int i = 0; i < DEPTH; i++) send_byte(8'h1C);
    check("fill_count", fifo_count, DEPTH);
    @(posedge clk); #2 hold_busy = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = tx_en;
    end
    check("coincident_tx_seen", seen, 1);
    m_room = -1;
    scancode = 8'h32; new_code = 1'b1;
    model_byte(8'h32);
    @(posedge clk); #2 new_code = 1'b0;
    @(negedge clk);
    check("coincident_count", fifo_count, DEPTH);
    check("coincident_overflow", overflow, 0);
    check("coincident_last", last_ascii, m_last);
    wait_drain();

    // Overflow: ten makes against a stalled UART.
    @(posedge clk); #2 hold_busy = 1'b1;
    m_room = DEPTH;
    for (int i = 0; i < 10; i++) send_byte(8'h1C);
    check("ovf_count", fifo_count, DEPTH);
    check("ovf_flag", overflow, 1);
    @(posedge clk); #2 hold_busy = 1'b0;
    m_room = -1;
    wait_drain();

    // Reset while a break prefix is pending.
    send_byte(8'hF0);
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst2_overflow", overflow, 0);
    check("rst2_fifo_count", fifo_count, 0);
    check("rst2_last_ascii", last_ascii, 0);
    send_byte(8'h1C);
    wait_drain();

    // Randomized byte stream, throttled so the queue never fills.
    for (int n = 0; n < 200; n++) begin
      for (int w = 0; w < 2000 && q.size() >= DEPTH - 1; w++) @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 50)      send_byte(pool[$urandom_range(0, 15)]);
      else if (r < 62) send_byte(8'hF0);
      else if (r < 68) send_byte(8'hE0);
      else if (r < 76) send_byte(($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59);
      else if (r < 80) send_byte(8'h58);
      else             send_byte(8'($urandom_range(0, 255)));
    end
    wait_drain();
    repeat (20) @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
